// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - N-digit packed-BCD up/down counter with clear, load and wrap/saturate
//
// Purpose:
//   Counts single-cycle up/down strobes in packed BCD, digit 0 least
//   significant. Operation priority per edge: clear > load > (up XOR down);
//   up and down together do nothing. At the limits the counter either wraps
//   (WRAP=1) or holds (WRAP=0). In both modes carry/borrow pulse for the
//   cycle in which a step past the limit was attempted.
//
// Parameters:
//   N_DIGITS    number of BCD digits (1..8)
//   WRAP        1: wrap max<->0, 0: saturate at max / 0
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   asynchronous active-high reset
//   up          in   increment strobe
//   down        in   decrement strobe
//   clear       in   synchronous clear strobe
//   load        in   synchronous parallel-load strobe
//   load_value  in   packed BCD value to load, invalid nibbles clamp to 9
//   digits      out  registered packed BCD count
//   carry       out  registered pulse, increment attempted at max
//   borrow      out  registered pulse, decrement attempted at zero
//   at_max      out  combinational, all digits are 9
//   at_zero     out  combinational, all digits are 0

module bcd_updown_counter #(
  parameter int N_DIGITS = 3,
  parameter int WRAP     = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    up,
  input  logic                    down,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_value,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic                    carry,
  output logic                    borrow,
  output logic                    at_max,
  output logic                    at_zero
);

  localparam int W = 4 * N_DIGITS;

  logic [W-1:0]        digits_q, digits_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;

  // Per-digit limit flags and their running AND from digit 0 upward.
  // low_nine[k] means every digit below k is 9, so digit k steps on an
  // increment; low_zero[k] is the decrement counterpart.
  logic [N_DIGITS-1:0] nine_v, zero_v;
  logic [N_DIGITS:0]   low_nine, low_zero;

  logic [W-1:0]        inc_val, dec_val, clamp_val;

  assign low_nine[0] = 1'b1;
  assign low_zero[0] = 1'b1;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [3:0] nib;
    logic [3:0] ld_nib;

    assign nib    = digits_q[4*k +: 4];
    assign ld_nib = load_value[4*k +: 4];

    assign nine_v[k] = (nib == 4'd9);
    assign zero_v[k] = (nib == 4'd0);

    assign low_nine[k+1] = low_nine[k] & nine_v[k];
    assign low_zero[k+1] = low_zero[k] & zero_v[k];

    // A digit that rolls past 9 becomes 0; one that borrows from 0 becomes 9.
    // When every digit rolls, the result is naturally the wrapped value.
    always_comb begin
      inc_val[4*k +: 4] = nib;
      if (low_nine[k]) begin
        inc_val[4*k +: 4] = nine_v[k] ? 4'd0 : nib + 4'd1;
      end
    end

    always_comb begin
      dec_val[4*k +: 4] = nib;
      if (low_zero[k]) begin
        dec_val[4*k +: 4] = zero_v[k] ? 4'd9 : nib - 4'd1;
      end
    end

    // Out-of-range load nibbles are forced to 9 so digits stay valid BCD.
    assign clamp_val[4*k +: 4] = (ld_nib > 4'd9) ? 4'd9 : ld_nib;
  end

  assign at_max  = low_nine[N_DIGITS];
  assign at_zero = low_zero[N_DIGITS];

  always_comb begin
    digits_d = digits_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (clear) begin
      digits_d = '0;
    end else if (load) begin
      digits_d = clamp_val;
    end else if (up && !down) begin
      if (at_max) begin
        carry_d = 1'b1;
        if (WRAP != 0) begin
          digits_d = inc_val;
        end
      end else begin
        digits_d = inc_val;
      end
    end else if (down && !up) begin
      if (at_zero) begin
        borrow_d = 1'b1;
        if (WRAP != 0) begin
          digits_d = dec_val;
        end
      end else begin
        digits_d = dec_val;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      digits_q <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign digits = digits_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - self-checking bench for bcd_updown_counter, wrap and saturate instances
//
// Purpose:
//   Drives one shared stimulus into a WRAP=1 and a WRAP=0 instance and
//   compares both against an integer-valued reference model every cycle,
//   plus a directed vector table and multi-cycle corner sequences.

module tb_bcd_updown_counter;

  localparam int N    = 3;
  localparam int W    = 4 * N;
  localparam int MAXV = 999;

  logic         CLK = 1'b0;
  logic         RST;
  logic         up, down, clear, load;
  logic [W-1:0] load_value;

  logic [W-1:0] dig_w, dig_s;
  logic         carry_w, borrow_w, at_max_w, at_zero_w;
  logic         carry_s, borrow_s, at_max_s, at_zero_s;

  bcd_updown_counter #(.N_DIGITS(N), .WRAP(1)) dut_w (
    .CLK(CLK), .RST(RST), .up(up), .down(down), .clear(clear), .load(load),
    .load_value(load_value), .digits(dig_w), .carry(carry_w), .borrow(borrow_w),
    .at_max(at_max_w), .at_zero(at_zero_w)
  );

  bcd_updown_counter #(.N_DIGITS(N), .WRAP(0)) dut_s (
    .CLK(CLK), .RST(RST), .up(up), .down(down), .clear(clear), .load(load),
    .load_value(load_value), .digits(dig_s), .carry(carry_s), .borrow(borrow_s),
    .at_max(at_max_s), .at_zero(at_zero_s)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state: the count as a plain integer 0..MAXV.
  int mv_w, mv_s;
  bit mc_w, mb_w, mc_s, mb_s;

  typedef struct {
    logic         u, d, c, l;
    logic [W-1:0] lv;
    logic [W-1:0] exp_dig;
    logic         exp_c, exp_b;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    r = '0;
    for (int k = 0; k < N; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_int(input logic [W-1:0] lv);
    int r;
    int p;
    int n;
    r = 0;
    p = 1;
    for (int k = 0; k < N; k++) begin
      n = int'(lv[4*k +: 4]);
      if (n > 9) n = 9;
      r += n * p;
      p *= 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit wrap, inout int v, output bit c, output bit b);
    c = 1'b0;
    b = 1'b0;
    if (clear) v = 0;
    else if (load) v = load_int(load_value);
    else if (up && !down) begin
      if (v == MAXV) begin
        c = 1'b1;
        if (wrap) v = 0;
      end else v = v + 1;
    end else if (down && !up) begin
      if (v == 0) begin
        b = 1'b1;
        if (wrap) v = MAXV;
      end else v = v - 1;
    end
  endtask

  task automatic model_reset();
    mv_w = 0; mv_s = 0;
    mc_w = 0; mb_w = 0; mc_s = 0; mb_s = 0;
  endtask

  task automatic compare_all();
    chk("w_digits",  32'(dig_w),     32'(to_bcd(mv_w)));
    chk("w_carry",   32'(carry_w),   32'(mc_w));
    chk("w_borrow",  32'(borrow_w),  32'(mb_w));
    chk("w_at_max",  32'(at_max_w),  32'(mv_w == MAXV));
    chk("w_at_zero", 32'(at_zero_w), 32'(mv_w == 0));
    chk("s_digits",  32'(dig_s),     32'(to_bcd(mv_s)));
    chk("s_carry",   32'(carry_s),   32'(mc_s));
    chk("s_borrow",  32'(borrow_s),  32'(mb_s));
    chk("s_at_max",  32'(at_max_s),  32'(mv_s == MAXV));
    chk("s_at_zero", 32'(at_zero_s), 32'(mv_s == 0));
  endtask

  task automatic drive(input logic u, input logic d, input logic c, input logic l,
                       input logic [W-1:0] lv);
    up = u; down = d; clear = c; load = l; load_value = lv;
  endtask

  // One clock: inputs are stable at the edge, model advances from the
  // sampled inputs, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge CLK);
    model_step(1'b1, mv_w, mc_w, mb_w);
    model_step(1'b0, mv_s, mc_s, mb_s);
    #1;
    compare_all();
  endtask

  int carry_cnt, carry_idx, borrow_cnt;
  int dir;

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h100, 12'h100, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h099, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'hA5F, 12'h959, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 12'h000, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h999, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h042, 12'h042, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 12'h042, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h043, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h099, 12'h099, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h100, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h999, 12'h999, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0};

    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    RST = 1'b0;

    // Directed vector table (expectations written for the wrap instance).
    foreach (tbl[i]) begin
      drive(tbl[i].u, tbl[i].d, tbl[i].c, tbl[i].l, tbl[i].lv);
      cycle();
      chk($sformatf("tbl%0d_digits", i), 32'(dig_w),    32'(tbl[i].exp_dig));
      chk($sformatf("tbl%0d_carry", i),  32'(carry_w),  32'(tbl[i].exp_c));
      chk($sformatf("tbl%0d_borrow", i), 32'(borrow_w), 32'(tbl[i].exp_b));
    end

    // 1000 ups from zero wrap back to zero with exactly one carry, on the last.
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    carry_cnt = 0;
    carry_idx = 0;
    for (int i = 1; i <= 1000; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle();
      if (carry_w) begin
        carry_cnt++;
        carry_idx = i;
      end
    end
    chk("up1000_digits", 32'(dig_w), 32'h000);
    chk("up1000_carry_count", 32'(carry_cnt), 32'd1);
    chk("up1000_carry_index", 32'(carry_idx), 32'd1000);

    // Load 100, one down to 099 without borrow, then 100 downs to 999.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h100);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    chk("down_099_digits", 32'(dig_w), 32'h099);
    chk("down_099_borrow", 32'(borrow_w), 32'd0);
    borrow_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (borrow_w) borrow_cnt++;
    end
    chk("down100_digits", 32'(dig_w), 32'h999);
    chk("down100_borrow_count", 32'(borrow_cnt), 32'd1);

    // Saturating instance: 997 + 3 ups holds at 999, carry only on the third.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h997);
    cycle();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cycle();
      chk($sformatf("sat_up%0d_carry", i), 32'(carry_s), 32'(i == 3));
    end
    chk("sat_up_digits", 32'(dig_s), 32'h999);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle();
    chk("sat_down0_digits", 32'(dig_s), 32'h000);
    chk("sat_down0_borrow", 32'(borrow_s), 32'd1);

    // Asynchronous reset between edges at 357, then one up after release.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h357);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_digits_w", 32'(dig_w), 32'h000);
    chk("async_rst_digits_s", 32'(dig_s), 32'h000);
    chk("async_rst_carry",    32'(carry_w), 32'd0);
    chk("async_rst_borrow",   32'(borrow_w), 32'd0);
    chk("async_rst_at_zero",  32'(at_zero_w), 32'd1);
    model_reset();
    #1;
    RST = 1'b0;
    cycle();
    chk("after_rst_up", 32'(dig_w), 32'h001);

    // Randomized traffic with a drifting bias so both limits get exercised.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 12'h990);
    cycle();
    dir = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 250 == 0) dir = -dir;
      r = $urandom_range(0, 99);
      if (r < 2) drive(1'b0, 1'b0, 1'b1, $urandom_range(0, 1) == 1, W'($urandom));
      else if (r < 6) drive(1'b0, 1'b0, 1'b0, 1'b1, W'($urandom));
      else if (r < 12) drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
      else if (r < 20) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      else if (r < 80) drive(dir > 0, dir < 0, 1'b0, 1'b0, W'($urandom));
      else drive(dir < 0, dir > 0, 1'b0, 1'b0, '0);
      cycle();
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
